// File: rtl/aes_spi_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : aes_spi_sync
// Description : Oversampled SPI front end for aes_core. Collects the
//               {plaintext,key} frame, starts the core and serves the result.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_spi_sync #(
  parameter int FRAME_BITS  = 256,
  parameter int OUT_BITS    = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sck,
  input  logic                    sdi,
  input  logic                    load,
  output logic                    sdo,
  output logic                    done,
  output logic [FRAME_BITS/2-1:0] plaintext,
  output logic [FRAME_BITS/2-1:0] key,
  output logic                    core_start,
  input  logic                    core_done,
  input  logic [OUT_BITS-1:0]     cyphertext
);

  localparam int c_IN_W  = $clog2(FRAME_BITS + 1);
  localparam int c_OUT_W = $clog2(OUT_BITS + 1);
  localparam logic [c_IN_W-1:0]  c_IN_FULL  = c_IN_W'(FRAME_BITS);
  localparam logic [c_OUT_W-1:0] c_OUT_LAST = c_OUT_W'(OUT_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SHIFT_IN  = 3'd1,
    S_START     = 3'd2,
    S_WAIT      = 3'd3,
    S_SHIFT_OUT = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic [SYNC_STAGES-1:0] r_load_sync;
  logic                   r_sck_d;
  logic                   r_load_d;

  logic w_sck_s, w_sdi_s, w_load_s;
  logic w_sck_rise, w_sck_fall, w_load_rise, w_load_fall;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [c_IN_W-1:0]         r_in_cnt;
  logic [c_OUT_W-1:0]        r_out_cnt;
  logic [FRAME_BITS-1:0]     r_frame;
  logic [OUT_BITS-1:0]       r_out;
  logic [FRAME_BITS/2-1:0]   r_pt;
  logic [FRAME_BITS/2-1:0]   r_key;
  logic                      r_done;

  logic w_clr_in, w_shift_in, w_launch, w_capture;
  logic w_out_tick, w_out_shift, w_finish, w_abort;

  // sdi travels through the same depth as sck so a sync sck rise sees its bit
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sck_sync  <= '0;
      r_sdi_sync  <= '0;
      r_load_sync <= '0;
      r_sck_d     <= 1'b0;
      r_load_d    <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
      r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], load};
      r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
      r_load_d    <= r_load_sync[SYNC_STAGES-1];
    end
  end

  assign w_sck_s     = r_sck_sync[SYNC_STAGES-1];
  assign w_sdi_s     = r_sdi_sync[SYNC_STAGES-1];
  assign w_load_s    = r_load_sync[SYNC_STAGES-1];
  assign w_sck_rise  = w_sck_s & ~r_sck_d;
  assign w_sck_fall  = ~w_sck_s & r_sck_d;
  assign w_load_rise = w_load_s & ~r_load_d;
  assign w_load_fall = ~w_load_s & r_load_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_in    = 1'b0;
    w_shift_in  = 1'b0;
    w_launch    = 1'b0;
    w_capture   = 1'b0;
    w_out_tick  = 1'b0;
    w_out_shift = 1'b0;
    w_finish    = 1'b0;
    w_abort     = 1'b0;
    // A new frame strobe always wins, restarting collection from any state
    if (w_load_rise) begin
      w_state_nxt = S_SHIFT_IN;
      w_clr_in    = 1'b1;
      w_abort     = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_SHIFT_IN: begin
          if (w_load_fall) begin
            w_launch    = (r_in_cnt == c_IN_FULL);
            w_state_nxt = (r_in_cnt == c_IN_FULL) ? S_START : S_IDLE;
          end else if (w_sck_rise && (r_in_cnt != c_IN_FULL)) begin
            w_shift_in = 1'b1;
          end
        end
        S_START: begin
          w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            w_capture   = 1'b1;
            w_state_nxt = S_SHIFT_OUT;
          end
        end
        S_SHIFT_OUT: begin
          if (w_sck_rise) begin
            w_out_tick = 1'b1;
            if (r_out_cnt == c_OUT_LAST) begin
              w_finish    = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
          w_out_shift = w_sck_fall;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_frame   <= '0;
      r_out     <= '0;
      r_pt      <= '0;
      r_key     <= '0;
      r_done    <= 1'b0;
    end else begin
      if (w_clr_in) begin
        r_in_cnt <= '0;
      end else if (w_shift_in) begin
        r_frame  <= {r_frame[FRAME_BITS-2:0], w_sdi_s};
        r_in_cnt <= r_in_cnt + c_IN_W'(1);
      end
      if (w_launch) begin
        r_pt  <= r_frame[FRAME_BITS-1 -: FRAME_BITS/2];
        r_key <= r_frame[FRAME_BITS/2-1:0];
      end
      if (w_capture) begin
        r_out     <= cyphertext;
        r_out_cnt <= '0;
        r_done    <= 1'b1;
      end else begin
        if (w_abort || w_finish) begin
          r_done <= 1'b0;
        end
        if (w_out_tick) begin
          r_out_cnt <= r_out_cnt + c_OUT_W'(1);
        end
        if (w_out_shift) begin
          r_out <= r_out << 1;
        end
      end
    end
  end

  assign plaintext  = r_pt;
  assign key        = r_key;
  assign done       = r_done;
  assign sdo        = r_done & r_out[OUT_BITS-1];
  // Gated by reset_n so a reset landing on the START cycle never reaches the core
  assign core_start = (r_state == S_START) & reset_n;

endmodule
`default_nettype wire
